dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Shares the single-port data memory (mem_write) between two requesters: port 0 = CPU load/store path, port 1 = loader/DMA.
//  Multi-cycle FSM: arbitrate, drive one memory access, return read data; round-robin fairness; saturating conflict counter.
//  Sits between the CPU datapath/CU and the DM_Addr/M_W_Data/Mem_Write/M_R_Data pins of mem_write; CPU stalls until gnt0.
// PARAMETERS
//  AW         32  address width (DM_Addr)
//  DW         32  data width (M_W_Data/M_R_Data)
//  CNT_W      16  width of conflict_cnt
//  MAX_BURST  4   max consecutive grants to one locked owner (only with DM_ARB_BURST_EN)
// PORTS
//  clk        in   1    clock; single clock domain; memory also clocked by clk
//  rst_n      in   1    reset, synchronous, active-low
//  req0/req1  in   1    access request; held with we/addr/wdata stable until gnt seen
//  we0/we1    in   1    1 = write, 0 = read
//  addr0/1    in   AW   byte address
//  wdata0/1   in   DW   write data
//  lock0/1    in   1    burst lock hint (ignored without DM_ARB_BURST_EN)
//  gnt0/gnt1  out  1    one-cycle pulse: request accepted, requester may drop/change req next cycle
//  rvalid0/1  out  1    one-cycle pulse: rdata valid for that port's read
//  rdata      out  DW   registered read data (shared; qualify with rvalidN)
//  DM_Addr    out  AW   memory address
//  M_W_Data   out  DW   memory write data
//  Mem_Write  out  1    memory write enable
//  M_R_Data   in   DW   memory read data, valid 1 cycle after address presented
//  busy       out  1    state != IDLE
//  conflict_cnt out CNT_W  saturating count of IDLE cycles with req0&req1
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, owner=0, prio=0, gnt*/rvalid*=0, rdata=0, conflict_cnt=0, burst_cnt=0.
//  States: IDLE -> ACCESS -> (we ? IDLE : RESP -> IDLE).
//   IDLE: if any req: owner = only requester, or prio if both; latch owner/we/addr/wdata; -> ACCESS. Else stay.
//   ACCESS: DM_Addr=addr_q, M_W_Data=wdata_q, Mem_Write=we_q & rst_n (combinational gate: no write commits on reset edge);
//           gntN pulse for owner this cycle; prio <= ~owner; write -> IDLE, read -> RESP.
//   RESP: rdata <= M_R_Data at end of cycle; rvalid[owner] pulses next cycle (in IDLE, overlapping next arbitration).
//  Latency: write = 2 cycles req->gnt-complete; read = req to rvalid 3 cycles; back-to-back reads one per 3 cycles.
//  Outside ACCESS: Mem_Write=0, DM_Addr/M_W_Data hold last latched values.
//  Single requester always wins regardless of prio; prio flips only when a grant issues.
//  conflict_cnt increments in IDLE when req0&req1, saturates at all-ones, never wraps.
//  Request dropped before gnt: already-latched access still completes (requesters must not drop; violation = bench error).
//  Reset mid-ACCESS/RESP: transaction aborted, no write, no rvalid; IDLE next cycle.
// CONFIGURATION
//  DM_ARB_BURST_EN defined: if owner's lockN high in ACCESS, prio stays = owner and burst_cnt++; when burst_cnt reaches
//   MAX_BURST, prio forced to other port and burst_cnt=0; lock low clears burst_cnt.
//  Undefined: lock0/lock1 ignored, pure alternation, no burst_cnt register.
// STRUCTURE
//  Shared package dm_arb_pkg: state encoding localparams (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), port index constants.
//  One sub-module natural: dm_arb_rr (2-way round-robin pick + prio/burst_cnt update); FSM/datapath regs in top.
// TESTING
//  T1 reset: hold rst_n=0 3 cycles with req0=1 -> gnt*/rvalid*/Mem_Write=0, conflict_cnt=0, busy=0.
//  T2 write then read port0: we0=1 addr=0x10 wdata=0xDEADBEEF -> Mem_Write=1 one cycle, gnt0; read 0x10 -> rvalid0 3 cycles after req, rdata=0xDEADBEEF.
//  T3 contention: req0=req1=1 reads continuously -> grants alternate 0,1,0,1 starting port0; conflict_cnt increments per arbitration.
//  T4 saturation: CNT_W=4, 20 conflicting arbitrations -> conflict_cnt=15, stays 15.
//  T5 reset mid-ACCESS on write to 0x20 -> Mem_Write=0 at that edge; later read 0x20 returns prior contents.
//  T6 DM_ARB_BURST_EN, MAX_BURST=4, lock0=1, both requesting -> grants 0,0,0,0,1,0,...; without macro -> 0,1,0,1.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester port indices and a small one-hot helper.
package dm_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic PORT0 = 1'b0;   // CPU load/store path
    localparam logic PORT1 = 1'b1;   // loader / DMA

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dm_arb_rr.sv
// Two-way round-robin picker for dm_arbiter. Holds the priority pointer and,
// when DM_ARB_BURST_EN is defined, the burst counter that lets a locked owner
// keep priority for up to MAX_BURST consecutive grants.
module dm_arb_rr
    import dm_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0_i,
    input  logic req1_i,
    input  logic grant_i,   // a grant is issuing this cycle
    input  logic owner_i,   // port receiving that grant
    input  logic lock0_i,
    input  logic lock1_i,
    output logic pick_o     // winner if arbitration happened this cycle
);

    logic prio_q, prio_d;

    // A lone requester always wins; priority only breaks ties
    assign pick_o = (req0_i & req1_i) ? prio_q : req1_i;

`ifdef DM_ARB_BURST_EN
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic          own_lock;

    // Priority/burst update on each grant: locked owner keeps priority until its burst is spent
    always_comb begin
        prio_d      = prio_q;
        burst_cnt_d = burst_cnt_q;
        own_lock    = (owner_i == PORT1) ? lock1_i : lock0_i;
        if (grant_i) begin
            if (own_lock) begin
                if (burst_cnt_q == BW'(MAX_BURST - 1)) begin
                    prio_d      = ~owner_i;
                    burst_cnt_d = '0;
                end else begin
                    prio_d      = owner_i;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end else begin
                prio_d      = ~owner_i;
                burst_cnt_d = '0;
            end
        end
    end

    // Priority and burst registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q      <= PORT0;
            burst_cnt_q <= '0;
        end else begin
            prio_q      <= prio_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{lock0_i, lock1_i, 32'(MAX_BURST)};

    // Pure alternation: the port just granted loses priority
    always_comb begin
        prio_d = prio_q;
        if (grant_i) begin
            prio_d = ~owner_i;
        end
    end

    // Priority register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= PORT0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and the
// loader/DMA (port 1). IDLE -> ACCESS -> (write ? IDLE : RESP -> IDLE).
// Optional burst locking is enabled by defining DM_ARB_BURST_EN.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [DW-1:0]    wdata0,
    input  logic [DW-1:0]    wdata1,
    input  logic             lock0,
    input  logic             lock1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [DW-1:0]    rdata,
    output logic [AW-1:0]    DM_Addr,
    output logic [DW-1:0]    M_W_Data,
    output logic             Mem_Write,
    input  logic [DW-1:0]    M_R_Data,
    output logic             busy,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pick;
    logic             access_gnt;

    // Reset is folded into the grant/write qualifiers so an access caught by
    // a reset edge neither commits to memory nor advances the round-robin.
    assign access_gnt = (state_q == ACCESS) & rst_n;

    dm_arb_rr #(
        .MAX_BURST(MAX_BURST)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0_i  (req0),
        .req1_i  (req1),
        .grant_i (access_gnt),
        .owner_i (owner_q),
        .lock0_i (lock0),
        .lock1_i (lock1),
        .pick_o  (pick)
    );

    assign gnt0         = access_gnt & (owner_q == PORT0);
    assign gnt1         = access_gnt & (owner_q == PORT1);
    assign Mem_Write    = access_gnt & we_q;
    assign DM_Addr      = addr_q;
    assign M_W_Data     = wdata_q;
    assign rvalid0      = rvalid_q[0];
    assign rvalid1      = rvalid_q[1];
    assign rdata        = rdata_q;
    assign busy         = (state_q != IDLE);
    assign conflict_cnt = cnt_q;

    // FSM next state, request latching, read capture and conflict counting
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req0 & req1 && cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (req0 | req1) begin
                    owner_d = pick;
                    we_d    = (pick == PORT1) ? we1    : we0;
                    addr_d  = (pick == PORT1) ? addr1  : addr0;
                    wdata_d = (pick == PORT1) ? wdata1 : wdata0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                rdata_d  = M_R_Data;
                rvalid_d = port_onehot(owner_q);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= PORT0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed transaction table, contention,
// saturation, reset-abort and burst sequences, then randomized traffic
// checked against a transaction-level reference model.
module tb_dm_arbiter;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        lock0 = 1'b0, lock1 = 1'b0;
    logic        gnt0, gnt1, rvalid0, rvalid1, Mem_Write, busy;
    logic [31:0] rdata, DM_Addr, M_W_Data;
    logic [31:0] M_R_Data;
    logic [CNT_W-1:0] conflict_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dm_arbiter #(
        .AW(32), .DW(32), .CNT_W(CNT_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .DM_Addr(DM_Addr), .M_W_Data(M_W_Data),
        .Mem_Write(Mem_Write), .M_R_Data(M_R_Data),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    // Memory device: synchronous write, registered read
    logic [31:0] dev_mem [64] = '{default: '0};
    always @(posedge clk) begin
        if (Mem_Write) dev_mem[DM_Addr[7:2]] <= M_W_Data;
        M_R_Data <= dev_mem[DM_Addr[7:2]];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single uncontended transaction; called at a negedge with the arbiter idle
    task automatic do_txn(input bit p, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] er);
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        @(negedge clk);
        chk("txn_gnt", {gnt1, gnt0}, p ? 2'b10 : 2'b01);
        chk("txn_mem_write", Mem_Write, w);
        chk("txn_addr", DM_Addr, a);
        if (w) chk("txn_wdata", M_W_Data, d);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        if (w) begin
            chk("txn_wr_idle", {busy, Mem_Write}, 2'b00);
        end else begin
            chk("txn_rv_early", {rvalid1, rvalid0}, 2'b00);
            @(negedge clk);
            chk("txn_rvalid", {rvalid1, rvalid0}, p ? 2'b10 : 2'b01);
            chk("txn_rdata", rdata, er);
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];
    bit   t6_exp[10];

    // Reference model state for the random phase
    logic [31:0] ref_mem [64] = '{default: '0};
    bit          prio_m;
    int          run_m;
    int          exp_cnt;
    bit          pend, pend_port;
    logic [31:0] pend_data;
    int          pend_due;
    logic [1:0]  preq, g;
    bit          own, exp_own, w, ol;
    logic [31:0] a, d;
    int          wt0, wt1, ngr;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h14, 32'hCAFEF00D, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b0, 32'h14, 32'h0,        32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b1, 32'h10, 32'h12345678, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'h12345678};
        vecs[7] = '{1'b1, 1'b0, 32'h18, 32'h0,        32'h0};
`ifdef DM_ARB_BURST_EN
        t6_exp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
        t6_exp = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif

        // T1: reset held with a pending request
        rst_n = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h55;
        repeat (3) begin
            @(negedge clk);
            chk("t1_gnt", {gnt1, gnt0}, 2'b00);
            chk("t1_rvalid", {rvalid1, rvalid0}, 2'b00);
            chk("t1_mem_write", Mem_Write, 1'b0);
            chk("t1_cnt", conflict_cnt, 0);
            chk("t1_busy", busy, 1'b0);
            chk("t1_rdata", rdata, 0);
        end
        rst_n = 1'b1; req0 = 1'b0;

        // T2: directed transaction table
        for (int i = 0; i < 8; i++)
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // T3/T4: continuous contention, alternation and counter saturation
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14;
        ngr = 0;
        for (int c = 0; c < 200 && ngr < 22; c++) begin
            @(negedge clk);
            if (gnt0 | gnt1) begin
                ngr++;
                if (ngr <= 6) chk("t3_order", gnt1, (ngr % 2) == 0);
                chk("t4_cnt", conflict_cnt, (ngr > 15) ? 15 : ngr);
            end
        end
        chk("t3_grants_seen", ngr, 22);
        repeat (3) @(negedge clk);
        chk("t4_cnt_hold", conflict_cnt, 15);

        // T5: reset during write ACCESS and during read RESP
        do_reset();
        do_txn(1'b0, 1'b1, 32'h20, 32'h11111111, 32'h0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h22222222;
        @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0;
        #1;
        chk("t5_mw_at_reset", Mem_Write, 1'b0);
        chk("t5_gnt_at_reset", {gnt1, gnt0}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_idle_after", busy, 1'b0);
        do_txn(1'b1, 1'b0, 32'h20, 32'h0, 32'h11111111);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_rv_abort", {rvalid1, rvalid0}, 2'b00);
        chk("t5_busy_abort", busy, 1'b0);
        @(negedge clk);
        chk("t5_rv_abort2", {rvalid1, rvalid0}, 2'b00);

        // T6: port 0 holding lock under contention
        do_reset();
        lock0 = 1'b1; lock1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14;
        ngr = 0;
        for (int c = 0; c < 100 && ngr < 10; c++) begin
            @(negedge clk);
            if (gnt0 | gnt1) begin
                chk("t6_order", gnt1, t6_exp[ngr]);
                ngr++;
            end
        end
        chk("t6_grants_seen", ngr, 10);

        // Random traffic against the reference model (addresses 0x80..0xFC start at zero)
        do_reset();
        prio_m = 1'b0; run_m = 0; exp_cnt = 0; pend = 1'b0; preq = 2'b00;
        wt0 = 0; wt1 = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            chk("rnd_cnt", conflict_cnt, exp_cnt);
            g = {gnt1, gnt0};
            if (g != 2'b00) begin
                chk("rnd_gnt_onehot", g == 2'b01 || g == 2'b10, 1'b1);
                own     = gnt1;
                exp_own = (preq == 2'b11) ? prio_m : preq[1];
                chk("rnd_owner", {preq != 2'b00, own}, {1'b1, exp_own});
                w = own ? we1 : we0;
                a = own ? addr1 : addr0;
                d = own ? wdata1 : wdata0;
                chk("rnd_mem_write", Mem_Write, w);
                chk("rnd_addr", DM_Addr, a);
                if (w) ref_mem[a[7:2]] = d;
                else begin
                    pend = 1'b1; pend_port = own; pend_data = ref_mem[a[7:2]]; pend_due = cyc + 2;
                end
            end else begin
                chk("rnd_mem_write_idle", Mem_Write, 1'b0);
            end
            if (pend && cyc == pend_due) begin
                chk("rnd_rvalid", {rvalid1, rvalid0}, pend_port ? 2'b10 : 2'b01);
                chk("rnd_rdata", rdata, pend_data);
                pend = 1'b0;
            end else begin
                chk("rnd_rvalid_none", {rvalid1, rvalid0}, 2'b00);
            end
            wt0 = (req0 && !gnt0) ? wt0 + 1 : 0;
            wt1 = (req1 && !gnt1) ? wt1 + 1 : 0;
            chk("rnd_starve", (wt0 > 24) || (wt1 > 24), 1'b0);

            // Requesters hold until granted, then may issue a new request
            if (!req0 || g[0]) begin
                req0 = $urandom_range(0, 9) < 6; we0 = $urandom_range(0, 1) == 1;
                addr0 = 32'h80 + ($urandom_range(0, 31) << 2); wdata0 = $urandom;
            end
            if (!req1 || g[1]) begin
                req1 = $urandom_range(0, 9) < 6; we1 = $urandom_range(0, 1) == 1;
                addr1 = 32'h80 + ($urandom_range(0, 31) << 2); wdata1 = $urandom;
            end
            lock0 = $urandom_range(0, 3) != 0;
            lock1 = $urandom_range(0, 3) != 0;

            if (g != 2'b00) begin
                ol = own ? lock1 : lock0;
`ifdef DM_ARB_BURST_EN
                if (ol) begin
                    run_m++;
                    if (run_m == MAX_BURST) begin prio_m = ~own; run_m = 0; end
                    else prio_m = own;
                end else begin
                    prio_m = ~own; run_m = 0;
                end
`else
                ol = 1'b0;
                prio_m = ~own;
`endif
            end
            if (!busy && req0 && req1 && exp_cnt < (2 ** CNT_W) - 1) exp_cnt++;
            preq = {req1, req0};
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        n_mis++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1);
    end

endmodule
